// File: rtl/prefetch_line_buffer.sv
// Next-line prefetch responder: accepts line-aligned prefetch requests,
// drops duplicates, fetches lines from the memory arbiter and holds them in
// a small fully associative FIFO buffer that the I-cache miss path probes.
module prefetch_line_buffer #(
  parameter int XLEN        = 32,
  parameter int BLK_SIZE    = 128,
  parameter int NUM_ENTRIES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                invalidate_i,
  input  logic                pf_valid_i,
  input  logic [XLEN-1:0]     pf_addr_i,
  output logic                pf_ack_o,
  output logic                busy_o,
  output logic                mem_req_valid_o,
  output logic [XLEN-1:0]     mem_req_addr_o,
  input  logic                mem_req_ready_i,
  input  logic                mem_rsp_valid_i,
  input  logic [BLK_SIZE-1:0] mem_rsp_data_i,
  input  logic                lookup_valid_i,
  input  logic [XLEN-1:0]     lookup_addr_i,
  output logic                lookup_hit_o,
  output logic [BLK_SIZE-1:0] lookup_data_o
);

  localparam int OFFSET_BITS = $clog2(BLK_SIZE / 8);
  localparam int TAG_W       = XLEN - OFFSET_BITS;
  localparam int PTR_W       = $clog2(NUM_ENTRIES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]             state_r;
  logic [1:0]             state_n_s;
  logic [XLEN-1:0]        req_addr_r;
  logic                   discard_r;
  logic [PTR_W-1:0]       alloc_ptr_r;
  logic [NUM_ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]       tag_r  [NUM_ENTRIES];
  logic [BLK_SIZE-1:0]    data_r [NUM_ENTRIES];

  logic [TAG_W-1:0]       pf_tag_s;
  logic [TAG_W-1:0]       lk_tag_s;
  logic                   dup_s;
  logic                   hit_any_s;
  logic [PTR_W-1:0]       hit_idx_s;
  logic                   hit_s;
  logic                   load_req_s;
  logic                   fill_s;
  logic                   unused_s;

  assign pf_tag_s = pf_addr_i[XLEN-1:OFFSET_BITS];
  assign lk_tag_s = lookup_addr_i[XLEN-1:OFFSET_BITS];
  assign unused_s = ^{pf_addr_i[OFFSET_BITS-1:0], lookup_addr_i[OFFSET_BITS-1:0]};

  // Tag match against registered entries; descending scan so the lowest index wins
  always_comb begin
    dup_s     = 1'b0;
    hit_any_s = 1'b0;
    hit_idx_s = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      dup_s = dup_s | (valid_r[i] & (tag_r[i] == pf_tag_s));
      if (valid_r[i] && (tag_r[i] == lk_tag_s)) begin
        hit_any_s = 1'b1;
        hit_idx_s = PTR_W'(i);
      end else begin
        hit_idx_s = hit_idx_s;
      end
    end
  end

  assign hit_s         = lookup_valid_i & hit_any_s;
  assign lookup_hit_o  = hit_s;
  assign lookup_data_o = hit_s ? data_r[hit_idx_s] : {BLK_SIZE{1'b0}};
  assign busy_o        = (state_r != ST_IDLE);

  // Next-state decode, request handshake and fill qualification
  always_comb begin
    state_n_s       = state_r;
    pf_ack_o        = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = {XLEN{1'b0}};
    load_req_s      = 1'b0;
    fill_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pf_ack_o = pf_valid_i & ~flush_i;
        if (pf_ack_o && !dup_s) begin
          load_req_s = 1'b1;
          state_n_s  = ST_REQ;
        end else begin
          state_n_s  = ST_IDLE;
        end
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = req_addr_r;
        if (flush_i) begin
          state_n_s = ST_IDLE;
        end else if (mem_req_ready_i) begin
          state_n_s = ST_WAIT;
        end else begin
          state_n_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        // The read cannot be cancelled; a flushed or invalidated line is dropped on arrival
        if (mem_rsp_valid_i) begin
          fill_s    = ~discard_r & ~flush_i & ~invalidate_i;
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_WAIT;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, captured request address and discard tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      req_addr_r <= {XLEN{1'b0}};
      discard_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      if (load_req_s) begin
        req_addr_r <= {pf_tag_s, {OFFSET_BITS{1'b0}}};
      end
      if (state_r == ST_WAIT) begin
        if (mem_rsp_valid_i) begin
          discard_r <= 1'b0;
        end else if (flush_i || invalidate_i) begin
          discard_r <= 1'b1;
        end
      end else begin
        discard_r <= 1'b0;
      end
    end
  end

  // Entry array: invalidate beats everything, a fill beats a same-index hit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r     <= {NUM_ENTRIES{1'b0}};
      alloc_ptr_r <= {PTR_W{1'b0}};
    end else if (invalidate_i) begin
      valid_r <= {NUM_ENTRIES{1'b0}};
    end else begin
      if (hit_s) begin
        valid_r[hit_idx_s] <= 1'b0;
      end
      if (fill_s) begin
        valid_r[alloc_ptr_r] <= 1'b1;
        tag_r[alloc_ptr_r]   <= req_addr_r[XLEN-1:OFFSET_BITS];
        data_r[alloc_ptr_r]  <= mem_rsp_data_i;
        alloc_ptr_r          <= alloc_ptr_r + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_line_buffer.sv
// Directed self-checking bench for prefetch_line_buffer.
module tb_prefetch_line_buffer;

  logic         clk = 1'b0;
  logic         rst_i, flush_i, invalidate_i;
  logic         pf_valid_i;
  logic [31:0]  pf_addr_i;
  logic         pf_ack_o, busy_o;
  logic         mem_req_valid_o;
  logic [31:0]  mem_req_addr_o;
  logic         mem_req_ready_i, mem_rsp_valid_i;
  logic [127:0] mem_rsp_data_i;
  logic         lookup_valid_i;
  logic [31:0]  lookup_addr_i;
  logic         lookup_hit_o;
  logic [127:0] lookup_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  prefetch_line_buffer #(.XLEN(32), .BLK_SIZE(128), .NUM_ENTRIES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .invalidate_i(invalidate_i),
    .pf_valid_i(pf_valid_i), .pf_addr_i(pf_addr_i), .pf_ack_o(pf_ack_o), .busy_o(busy_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .lookup_valid_i(lookup_valid_i),
    .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o), .lookup_data_o(lookup_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dat(input logic [31:0] a);
    return {4{32'hD000_0000 | a}};
  endfunction

  // Plain fill: ready on the first REQ cycle, response one cycle later
  task automatic do_fill(input logic [31:0] addr, input logic [127:0] data);
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = addr;
    @(negedge clk); pf_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = data;
    @(negedge clk); mem_rsp_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; invalidate_i = 1'b0;
    pf_valid_i = 1'b0; pf_addr_i = 32'h0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = 128'h0;
    lookup_valid_i = 1'b0; lookup_addr_i = 32'h0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mreq", mem_req_valid_o, 1'b0);
    chk("rst_maddr", mem_req_addr_o, 32'h0);
    chk("rst_ack", pf_ack_o, 1'b0);
    chk("rst_hit", lookup_hit_o, 1'b0);
    chk("rst_ldata", lookup_data_o, 128'h0);
    chk("rst_valid", dut.valid_r, 4'b0000);
    rst_i = 1'b0;

    // Basic fill
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = 32'h1010; #1;
    chk("basic_ack", pf_ack_o, 1'b1);
    chk("basic_busy_idle", busy_o, 1'b0);
    @(negedge clk); pf_valid_i = 1'b0; #1;
    chk("basic_ack_drop", pf_ack_o, 1'b0);
    chk("basic_mreq", mem_req_valid_o, 1'b1);
    chk("basic_maddr", mem_req_addr_o, 32'h1010);
    chk("basic_busy_req", busy_o, 1'b1);
    @(negedge clk); #1;
    chk("basic_mreq_held", mem_req_valid_o, 1'b1);
    @(negedge clk); mem_req_ready_i = 1'b1;
    @(negedge clk); mem_req_ready_i = 1'b0; #1;
    chk("basic_mreq_done", mem_req_valid_o, 1'b0);
    chk("basic_busy_wait", busy_o, 1'b1);
    @(negedge clk);
    @(negedge clk); mem_rsp_valid_i = 1'b1; mem_rsp_data_i = {16{8'hA5}};
    @(negedge clk); mem_rsp_valid_i = 1'b0; #1;
    chk("basic_busy_end", busy_o, 1'b0);
    chk("basic_entry0", dut.valid_r[0], 1'b1);
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h101C; #1;
    chk("basic_hit", lookup_hit_o, 1'b1);
    chk("basic_data", lookup_data_o, {16{8'hA5}});
    @(negedge clk); lookup_addr_i = 32'h1010; #1;
    chk("basic_consumed", lookup_hit_o, 1'b0);
    chk("basic_miss_data", lookup_data_o, 128'h0);
    lookup_valid_i = 1'b0;

    // Duplicate
    do_fill(32'h2000, dat(32'h2000));
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = 32'h2008; #1;
    chk("dup_ack", pf_ack_o, 1'b1);
    @(negedge clk); pf_valid_i = 1'b0; #1;
    chk("dup_mreq", mem_req_valid_o, 1'b0);
    chk("dup_busy", busy_o, 1'b0);
    @(negedge clk); #1;
    chk("dup_mreq2", mem_req_valid_o, 1'b0);
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h2000; #1;
    chk("dup_hit", lookup_hit_o, 1'b1);
    chk("dup_data", lookup_data_o, dat(32'h2000));
    @(negedge clk); lookup_valid_i = 1'b0;

    // FIFO wrap from a clean reset
    rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;
    do_fill(32'h100, dat(32'h100));
    do_fill(32'h110, dat(32'h110));
    do_fill(32'h120, dat(32'h120));
    do_fill(32'h130, dat(32'h130));
    do_fill(32'h140, dat(32'h140));
    #1;
    chk("wrap_ptr", dut.alloc_ptr_r, 2'd1);
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h100; #1;
    chk("wrap_old_miss", lookup_hit_o, 1'b0);
    @(negedge clk); lookup_addr_i = 32'h140; #1;
    chk("wrap_new_hit", lookup_hit_o, 1'b1);
    chk("wrap_new_data", lookup_data_o, dat(32'h140));
    @(negedge clk); lookup_valid_i = 1'b0;

    // Fill into index 2 while the old entry 2 is hit
    do_fill(32'h150, dat(32'h150));
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = 32'h160;
    @(negedge clk); pf_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = dat(32'h160);
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h120; #1;
    chk("sim_old_hit", lookup_hit_o, 1'b1);
    chk("sim_old_data", lookup_data_o, dat(32'h120));
    @(negedge clk); mem_rsp_valid_i = 1'b0; #1;
    chk("sim_old_gone", lookup_hit_o, 1'b0);
    chk("sim_entry2", dut.valid_r[2], 1'b1);
    @(negedge clk); lookup_addr_i = 32'h160; #1;
    chk("sim_new_hit", lookup_hit_o, 1'b1);
    chk("sim_new_data", lookup_data_o, dat(32'h160));
    @(negedge clk); lookup_valid_i = 1'b0;

    // Invalidate in the same cycle as a fill
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = 32'h170;
    @(negedge clk); pf_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = dat(32'h170);
    invalidate_i = 1'b1;
    @(negedge clk); mem_rsp_valid_i = 1'b0; invalidate_i = 1'b0; #1;
    chk("inv_valid", dut.valid_r, 4'b0000);
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h170; #1;
    chk("inv_fill_miss", lookup_hit_o, 1'b0);
    @(negedge clk); lookup_addr_i = 32'h130; #1;
    chk("inv_old_miss", lookup_hit_o, 1'b0);
    @(negedge clk); lookup_valid_i = 1'b0;

    // Flush while in REQ
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = 32'h3000;
    @(negedge clk); pf_valid_i = 1'b0; #1;
    chk("fl1_mreq", mem_req_valid_o, 1'b1);
    flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0; #1;
    chk("fl1_busy", busy_o, 1'b0);
    chk("fl1_mreq_off", mem_req_valid_o, 1'b0);
    @(negedge clk); #1;
    chk("fl1_mreq_off2", mem_req_valid_o, 1'b0);

    // Flush while in WAIT_RSP
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = 32'h3100;
    @(negedge clk); pf_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk); mem_req_ready_i = 1'b0; flush_i = 1'b1; #1;
    chk("fl2_busy_a", busy_o, 1'b1);
    @(negedge clk); flush_i = 1'b0; #1;
    chk("fl2_busy_b", busy_o, 1'b1);
    @(negedge clk); mem_rsp_valid_i = 1'b1; mem_rsp_data_i = dat(32'h3100);
    @(negedge clk); mem_rsp_valid_i = 1'b0; #1;
    chk("fl2_idle", busy_o, 1'b0);
    chk("fl2_valid", dut.valid_r, 4'b0000);
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h3100; #1;
    chk("fl2_miss", lookup_hit_o, 1'b0);
    @(negedge clk); lookup_valid_i = 1'b0;

    // Reset in WAIT_RSP, then a late response
    @(negedge clk); pf_valid_i = 1'b1; pf_addr_i = 32'h4000;
    @(negedge clk); pf_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk); mem_req_ready_i = 1'b0; #1;
    chk("rw_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0; #1;
    chk("rw_busy_off", busy_o, 1'b0);
    chk("rw_mreq", mem_req_valid_o, 1'b0);
    chk("rw_maddr", mem_req_addr_o, 32'h0);
    chk("rw_ack", pf_ack_o, 1'b0);
    chk("rw_ldata", lookup_data_o, 128'h0);
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = dat(32'h4000);
    @(negedge clk); mem_rsp_valid_i = 1'b0; #1;
    chk("late_valid", dut.valid_r, 4'b0000);
    chk("late_busy", busy_o, 1'b0);
    lookup_valid_i = 1'b1; lookup_addr_i = 32'h4000; #1;
    chk("late_miss", lookup_hit_o, 1'b0);
    @(negedge clk); lookup_valid_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_line_buffer.md
Name: prefetch_line_buffer

Overview:
- Responder side of the next-line prefetch interface. Accepts line-aligned prefetch requests, drops duplicates, and fetches each line from the memory arbiter.
- Holds fetched lines in a small fully associative buffer.
- The I-cache miss path probes this buffer before going to memory. A hit supplies the line immediately and frees the entry.
- Sits between the next-line prefetcher, the I-cache refill path and the memory arbiter in stage01_fetch.

Parameters:
- XLEN, 32, address width.
- BLK_SIZE, 128, line size in bits; OFFSET_BITS = $clog2(BLK_SIZE/8).
- NUM_ENTRIES, 4, number of buffer entries; must be a power of two and at least 2.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; aborts a request that has not yet been issued.
- invalidate_i  in  1  fence.i; clears every entry valid bit.
- pf_valid_i  in  1  prefetch request valid.
- pf_addr_i  in  XLEN  prefetch line address; low OFFSET_BITS are ignored.
- pf_ack_o  out  1  request accepted, one-cycle pulse.
- busy_o  out  1  engine not idle; drives the prefetcher's cache_busy_i.
- mem_req_valid_o  out  1  memory read request.
- mem_req_addr_o  out  XLEN  line-aligned read address.
- mem_req_ready_i  in  1  arbiter accepts the request.
- mem_rsp_valid_i  in  1  line data valid.
- mem_rsp_data_i  in  BLK_SIZE  line data.
- lookup_valid_i  in  1  I-cache miss probe.
- lookup_addr_i  in  XLEN  probe address.
- lookup_hit_o  out  1  probe hit; combinational.
- lookup_data_o  out  BLK_SIZE  line for the hit entry; '0 when there is no hit.

Behaviour:
- Reset (rst_i=1 at the edge):
  - state=IDLE, all entry valids=0, alloc_ptr=0, discard_q=0, req_addr_q='0.
  - All outputs are 0.
- Tag is addr[XLEN-1:OFFSET_BITS].
- A duplicate is a pf tag that equals the tag of any valid entry.
- FSM states:
  - IDLE:
    - pf_ack_o = pf_valid_i & ~flush_i. This is combinational, with zero-cycle latency.
    - If the request is acked and is a duplicate, stay in IDLE and issue no memory request.
    - If the request is acked and is not a duplicate, capture req_addr_q = {tag, OFFSET_BITS'0} and go to REQ.
  - REQ:
    - mem_req_valid_o=1 and mem_req_addr_o=req_addr_q.
    - flush_i=1 goes to IDLE, with no request issued.
    - Otherwise, mem_req_ready_i=1 goes to WAIT_RSP.
  - WAIT_RSP:
    - The outstanding read cannot be cancelled.
    - flush_i or invalidate_i sets discard_q.
    - On mem_rsp_valid_i:
      - If discard_q=0 (and invalidate_i is not asserted in the same cycle), write entry[alloc_ptr] = {valid=1, tag, data} and advance alloc_ptr modulo NUM_ENTRIES.
      - Clear discard_q and go to IDLE.
    - A response arriving in the same cycle as flush_i is discarded.
- pf_ack_o is 0 outside IDLE. No new request is accepted until the FSM returns to IDLE.
- busy_o = (state != IDLE).
- mem_req_valid_o is held until ready. req_addr_q is stable while in REQ.
- Lookup:
  - lookup_hit_o = lookup_valid_i & any(valid & tag match), using registered entry state only.
  - On a hit, that entry's valid is cleared at the next edge; the line is consumed.
  - If more than one entry matches, which can only happen through a protocol error, the lowest index wins.
  - A lookup that matches an in-flight req_addr_q misses.
- Simultaneous events:
  - If a fill and a hit target the same index in one cycle, the fill wins and the entry remains valid with the new line.
  - invalidate_i clears all valids at the next edge and overrides any same-cycle fill or hit.
  - flush_i does not clear entries.
- Replacement is strict FIFO through alloc_ptr, which overwrites valid entries. alloc_ptr wraps from NUM_ENTRIES-1 to 0.
- Reset mid-operation returns to the reset state immediately. A late mem_rsp_valid_i in IDLE is ignored.

Test Plan:
- Basic fill:
  - Stimulus: pf_valid_i with pf_addr_i=0x1010, ready after 2 cycles, response 3 cycles later with data 0xA5..A5.
  - Required: ack on cycle 0, mem_req_addr_o=0x1010, entry 0 valid; then lookup 0x101C gives hit=1 with that data, and a second lookup of 0x1010 misses.
- Duplicate:
  - Stimulus: fill 0x2000, then pf 0x2008.
  - Required: ack pulse on the second request, no mem_req_valid_o, busy_o stays 0.
- FIFO wrap:
  - Stimulus: fill 0x100, 0x110, 0x120, 0x130, 0x140 with NUM_ENTRIES=4.
  - Required: lookup 0x100 misses; lookup 0x140 hits; alloc_ptr=1.
- Flush:
  - Stimulus 1: flush_i while in REQ.
    - Required: IDLE next cycle with no request issued.
  - Stimulus 2: flush_i while in WAIT_RSP.
    - Required: response absorbed, no entry written, IDLE after the response.
- Simultaneous events:
  - Stimulus 1: fill to index 2 in the same cycle as a hit on the old entry 2.
    - Required: entry 2 is valid with the new tag.
  - Stimulus 2: invalidate_i in the same cycle as a fill.
    - Required: all entries invalid.
- Reset:
  - Stimulus 1: rst_i while in WAIT_RSP.
    - Required: state IDLE, all outputs 0 next cycle.
  - Stimulus 2: a late mem_rsp_valid_i after the reset.
    - Required: no entry becomes valid.
